// File: rtl/hpdcache_miss_refill.sv
// rtl/hpdcache_miss_refill.sv - collects refill beats into a line, acks the owning MSHR entry and emits the line.
// Optional HPDCACHE_REFILL_ERR_CHECK_EN adds beat/protocol error tracking on refill_error_o.
module hpdcache_miss_refill #(
    parameter int MSHR_SET_WIDTH = 2,
    parameter int MSHR_WAY_WIDTH = 2,
    parameter int BEATS          = 4,
    parameter int BEAT_WIDTH     = 64,
    parameter int TID_WIDTH      = 6
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   mem_rsp_valid_i,
    output logic                                   mem_rsp_ready_o,
    input  logic [MSHR_WAY_WIDTH+MSHR_SET_WIDTH-1:0] mem_rsp_id_i,
    input  logic [BEAT_WIDTH-1:0]                  mem_rsp_data_i,
    input  logic                                   mem_rsp_last_i,
    input  logic                                   mem_rsp_error_i,
    output logic                                   mshr_ack_o,
    output logic                                   mshr_ack_cs_o,
    output logic [MSHR_SET_WIDTH-1:0]              mshr_ack_set_o,
    output logic [MSHR_WAY_WIDTH-1:0]              mshr_ack_way_o,
    input  logic [TID_WIDTH-1:0]                   mshr_ack_req_id_i,
    input  logic                                   mshr_ack_need_rsp_i,
    output logic                                   refill_valid_o,
    input  logic                                   refill_ready_i,
    output logic [BEATS*BEAT_WIDTH-1:0]            refill_data_o,
    output logic [TID_WIDTH-1:0]                   refill_req_id_o,
    output logic                                   refill_need_rsp_o,
    output logic                                   refill_error_o,
    output logic                                   busy_o
);

    localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ID_W = MSHR_WAY_WIDTH + MSHR_SET_WIDTH;

    typedef enum logic [1:0] {COLLECT, ACK, RDATA, EMIT} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q;
    logic [BEAT_WIDTH-1:0]        buf_q [BEATS];
    logic [ID_W-1:0]              id_q;
    logic [BEATS*BEAT_WIDTH-1:0]  line_q, line_next;
    logic [TID_WIDTH-1:0]         req_id_q;
    logic                         need_rsp_q;

    logic beat_acc, cnt_full, line_done, handshake;

    assign beat_acc  = mem_rsp_valid_i && (state_q == COLLECT);
    assign cnt_full  = (cnt_q == CW'(BEATS - 1));
    assign line_done = beat_acc && (mem_rsp_last_i || cnt_full);
    assign handshake = (state_q == EMIT) && refill_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= COLLECT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (line_done) state_d = ACK;
            ACK:     state_d = RDATA;
            RDATA:   state_d = EMIT;
            EMIT:    if (refill_ready_i) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        mem_rsp_ready_o = (state_q == COLLECT);
        mshr_ack_o      = (state_q == ACK);
        mshr_ack_cs_o   = (state_q == ACK);
        refill_valid_o  = (state_q == EMIT);
    end

    // The completing beat goes straight into the output line; untouched slots are already zero.
    always_comb begin
        line_next = '0;
        for (int k = 0; k < BEATS; k++) begin
            line_next[k*BEAT_WIDTH +: BEAT_WIDTH] = (cnt_q == CW'(k)) ? mem_rsp_data_i : buf_q[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            id_q       <= '0;
            line_q     <= '0;
            req_id_q   <= '0;
            need_rsp_q <= 1'b0;
            for (int k = 0; k < BEATS; k++) buf_q[k] <= '0;
        end else begin
            if (beat_acc) begin
                if (cnt_q == '0) id_q <= mem_rsp_id_i;
                if (line_done) begin
                    cnt_q  <= '0;
                    line_q <= line_next;
                    for (int k = 0; k < BEATS; k++) buf_q[k] <= '0;
                end else begin
                    cnt_q        <= cnt_q + CW'(1);
                    buf_q[cnt_q] <= mem_rsp_data_i;
                end
            end
            if (state_q == RDATA) begin
                req_id_q   <= mshr_ack_req_id_i;
                need_rsp_q <= mshr_ack_need_rsp_i;
            end
        end
    end

    assign mshr_ack_set_o    = id_q[MSHR_SET_WIDTH-1:0];
    assign mshr_ack_way_o    = id_q[ID_W-1:MSHR_SET_WIDTH];
    assign refill_data_o     = line_q;
    assign refill_req_id_o   = req_id_q;
    assign refill_need_rsp_o = need_rsp_q;
    assign busy_o            = (state_q != COLLECT) || (cnt_q != '0);

`ifdef HPDCACHE_REFILL_ERR_CHECK_EN
    logic err_q;
    logic proto_err;

    // Early last, or a full line without last, both flag a malformed refill.
    assign proto_err = line_done && (mem_rsp_last_i != cnt_full);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       err_q <= 1'b0;
        else if (handshake) err_q <= 1'b0;
        else if (beat_acc)  err_q <= err_q | mem_rsp_error_i | proto_err;
    end

    assign refill_error_o = err_q;
`else
    logic unused_err;
    assign unused_err     = mem_rsp_error_i ^ handshake;
    assign refill_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpdcache_miss_refill.sv
// tb/tb_hpdcache_miss_refill.sv - randomized scoreboard bench for hpdcache_miss_refill.
module tb_hpdcache_miss_refill;

    localparam int SW = 2, WW = 2, BEATS = 4, BW = 64, TW = 6;
    localparam int IDW = SW + WW, LW = BEATS * BW;

    logic            clk_i = 1'b0, rst_ni = 1'b0;
    logic            mem_rsp_valid_i = 1'b0, mem_rsp_ready_o;
    logic [IDW-1:0]  mem_rsp_id_i = '0;
    logic [BW-1:0]   mem_rsp_data_i = '0;
    logic            mem_rsp_last_i = 1'b0, mem_rsp_error_i = 1'b0;
    logic            mshr_ack_o, mshr_ack_cs_o;
    logic [SW-1:0]   mshr_ack_set_o;
    logic [WW-1:0]   mshr_ack_way_o;
    logic [TW-1:0]   mshr_ack_req_id_i = '0;
    logic            mshr_ack_need_rsp_i = 1'b0;
    logic            refill_valid_o, refill_ready_i = 1'b0;
    logic [LW-1:0]   refill_data_o;
    logic [TW-1:0]   refill_req_id_o;
    logic            refill_need_rsp_o, refill_error_o, busy_o;

    hpdcache_miss_refill #(
        .MSHR_SET_WIDTH(SW), .MSHR_WAY_WIDTH(WW), .BEATS(BEATS), .BEAT_WIDTH(BW), .TID_WIDTH(TW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_id_i(mem_rsp_id_i), .mem_rsp_data_i(mem_rsp_data_i),
        .mem_rsp_last_i(mem_rsp_last_i), .mem_rsp_error_i(mem_rsp_error_i),
        .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
        .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o),
        .mshr_ack_req_id_i(mshr_ack_req_id_i), .mshr_ack_need_rsp_i(mshr_ack_need_rsp_i),
        .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
        .refill_data_o(refill_data_o), .refill_req_id_o(refill_req_id_o),
        .refill_need_rsp_o(refill_need_rsp_o), .refill_error_o(refill_error_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [LW-1:0] data;
        logic          err;
        logic [SW-1:0] set;
        logic [WW-1:0] way;
        logic [TW-1:0] rid;
        logic          nrsp;
        int            t_last;
    } exp_t;

    exp_t          exp_q[$];
    logic [TW-1:0] mshr_rid  [1<<SW][1<<WW];
    logic          mshr_nrsp [1<<SW][1<<WW];
    int            n_chk = 0, n_fail = 0;
    int            cyc = 0;
    bit            hold_mode = 0;
    int            hold_cnt = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, LW'(mem_rsp_ready_o), LW'(1));
        check({tag, "_ack"}, LW'({mshr_ack_o, mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o}), '0);
        check({tag, "_refill_valid"}, LW'(refill_valid_o), '0);
        check({tag, "_refill_data"}, refill_data_o, '0);
        check({tag, "_refill_meta"}, LW'({refill_req_id_o, refill_need_rsp_o, refill_error_o}), '0);
        check({tag, "_busy"}, LW'(busy_o), '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            mem_rsp_valid_i = 1'b0;
        end
    endtask

    // Presents one beat and returns the cycle in which it was accepted.
    task automatic send_beat(input logic [BW-1:0] d, input logic [IDW-1:0] id,
                             input logic last, input logic err, output int t);
        int guard = 0;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = d;
        mem_rsp_id_i    = id;
        mem_rsp_last_i  = last;
        mem_rsp_error_i = err;
        forever begin
            t = cyc;
            if (mem_rsp_ready_o) begin
                @(posedge clk_i);
                break;
            end
            guard++;
            if (guard > 200) begin
                n_chk++; n_fail++;
                $display("FAIL beat_accept_timeout: got no ready expected ready within 200 cycles");
                finish_test();
            end
            @(negedge clk_i);
        end
    endtask

    // err_beat: -1 random errors, -2 none, k>=0 error only on beat k.
    task automatic send_line(input int n, input bit last_final, input logic [IDW-1:0] id,
                             input bit directed, input int err_beat);
        logic [LW-1:0] line = '0;
        logic          errs = 1'b0;
        logic [BW-1:0] d;
        logic          e, l;
        int            t = 0;
        exp_t          x;
        for (int b = 0; b < n; b++) begin
            d = directed ? BW'((b + 1) * 'h11) : {$urandom, $urandom};
            e = (err_beat == -1) ? ($urandom_range(0, 7) == 0) : (err_beat == b);
            l = (b == n - 1) ? ((n < BEATS) ? 1'b1 : last_final) : 1'b0;
            idle($urandom_range(0, 1));
            send_beat(d, (b == 0) ? id : IDW'($urandom), l, e, t);
            line[b*BW +: BW] = d;
            errs |= e;
        end
        x.data   = line;
`ifdef HPDCACHE_REFILL_ERR_CHECK_EN
        x.err    = errs | (n < BEATS) | (n == BEATS && !last_final);
`else
        x.err    = 1'b0;
`endif
        x.set    = id[SW-1:0];
        x.way    = id[IDW-1:SW];
        x.rid    = mshr_rid[x.set][x.way];
        x.nrsp   = mshr_nrsp[x.set][x.way];
        x.t_last = t;
        exp_q.push_back(x);
    endtask

    // Monitor, MSHR read-data responder and refill consumer share one process so ready is decided before it is checked.
    bit            ack_d = 0, emit_seen = 0;
    logic [SW-1:0] ack_set_d;
    logic [WW-1:0] ack_way_d;

    always @(negedge clk_i) begin
        if (ack_d) begin
            mshr_ack_req_id_i   = mshr_rid[ack_set_d][ack_way_d];
            mshr_ack_need_rsp_i = mshr_nrsp[ack_set_d][ack_way_d];
        end else begin
            mshr_ack_req_id_i   = TW'($urandom);
            mshr_ack_need_rsp_i = 1'($urandom);
        end
        if (!rst_ni) begin
            ack_d = 0;
            emit_seen = 0;
        end else begin
            ack_d = 0;
            if (mshr_ack_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", LW'(mshr_ack_o), '0);
                end else begin
                    check("ack_set", LW'(mshr_ack_set_o), LW'(exp_q[0].set));
                    check("ack_way", LW'(mshr_ack_way_o), LW'(exp_q[0].way));
                    check("ack_cs", LW'(mshr_ack_cs_o), LW'(1));
                    check("ack_latency", LW'(cyc), LW'(exp_q[0].t_last + 1));
                    check("ack_backpressure", LW'(mem_rsp_ready_o), '0);
                end
                ack_d = 1;
                ack_set_d = mshr_ack_set_o;
                ack_way_d = mshr_ack_way_o;
            end
            if (hold_mode && refill_valid_o && hold_cnt < 5) begin
                refill_ready_i = 1'b0;
                hold_cnt++;
            end else begin
                refill_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (refill_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_refill", LW'(refill_valid_o), '0);
                end else begin
                    if (!emit_seen) check("refill_latency", LW'(cyc), LW'(exp_q[0].t_last + 3));
                    emit_seen = 1;
                    check("refill_data", refill_data_o, exp_q[0].data);
                    check("refill_error", LW'(refill_error_o), LW'(exp_q[0].err));
                    check("refill_req_id", LW'(refill_req_id_o), LW'(exp_q[0].rid));
                    check("refill_need_rsp", LW'(refill_need_rsp_o), LW'(exp_q[0].nrsp));
                    check("emit_backpressure", LW'(mem_rsp_ready_o), '0);
                    if (refill_ready_i) begin
                        void'(exp_q.pop_front());
                        emit_seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        for (int s = 0; s < (1 << SW); s++)
            for (int w = 0; w < (1 << WW); w++) begin
                mshr_rid[s][w]  = TW'($urandom);
                mshr_nrsp[s][w] = 1'($urandom);
            end
        mshr_rid[2][1]  = 6'h2A;
        mshr_nrsp[2][1] = 1'b1;

        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("reset");

        send_line(4, 1'b1, {2'd1, 2'd2}, 1'b1, -2);
        send_line(4, 1'b1, IDW'($urandom), 1'b0, 2);
        send_line(4, 1'b1, IDW'($urandom), 1'b0, -2);
        send_line(2, 1'b1, IDW'($urandom), 1'b0, -2);
        hold_mode = 1;
        send_line(4, 1'b1, IDW'($urandom), 1'b0, -1);
        send_line(4, 1'b0, IDW'($urandom), 1'b0, -1);

        // Abandon a two-beat partial line with a reset pulse.
        idle(12);
        send_beat(BW'($urandom), IDW'($urandom), 1'b0, 1'b0, t);
        send_beat(BW'($urandom), IDW'($urandom), 1'b0, 1'b0, t);
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("midline_reset");
        idle(4);
        send_line(4, 1'b1, IDW'($urandom), 1'b0, -2);

        for (int i = 0; i < 40; i++) begin
            int n;
            n = $urandom_range(1, BEATS);
            send_line(n, 1'($urandom), IDW'($urandom), 1'b0, -1);
        end
        idle(1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_i);
        check("drain_empty", LW'(exp_q.size()), '0);
        check("final_idle_busy", LW'(busy_o), '0);
        finish_test();
    end

endmodule

// File: doc/hpdcache_miss_refill.md
HPDCACHE_MISS_REFILL -- requirements
Module: hpdcache_miss_refill

Interface
REQ-001 SHALL have parameter MSHR_SET_WIDTH, default 2, width of the MSHR set index.
REQ-002 SHALL have parameter MSHR_WAY_WIDTH, default 2, width of the MSHR way index.
REQ-003 SHALL have parameter BEATS, default 4, memory beats per cache line (power of two, >=2).
REQ-004 SHALL have parameter BEAT_WIDTH, default 64, data bits per beat.
REQ-005 SHALL have parameter TID_WIDTH, default 6, core request transaction id width.
REQ-006 SHALL have ports:
 clk_i  in  1  clock
 rst_ni  in  1  reset, asynchronous, active-low
 mem_rsp_valid_i  in  1  refill beat valid
 mem_rsp_ready_o  out  1  refill beat accepted
 mem_rsp_id_i  in  MSHR_WAY_WIDTH+MSHR_SET_WIDTH  {way,set} of the owning MSHR entry
 mem_rsp_data_i  in  BEAT_WIDTH  beat data
 mem_rsp_last_i  in  1  final beat of line
 mem_rsp_error_i  in  1  memory error on beat
 mshr_ack_o  out  1  MSHR ack strobe (frees entry)
 mshr_ack_cs_o  out  1  MSHR RAM chip select for ack read
 mshr_ack_set_o  out  MSHR_SET_WIDTH  ack set
 mshr_ack_way_o  out  MSHR_WAY_WIDTH  ack way
 mshr_ack_req_id_i  in  TID_WIDTH  MSHR read data, valid cycle after ack
 mshr_ack_need_rsp_i  in  1  MSHR read data, valid cycle after ack
 refill_valid_o  out  1  assembled line valid
 refill_ready_i  in  1  consumer accepts line
 refill_data_o  out  BEATS*BEAT_WIDTH  line, beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
 refill_req_id_o  out  TID_WIDTH  originating request id
 refill_need_rsp_o  out  1  core response required
 refill_error_o  out  1  line erroneous
 busy_o  out  1  state != COLLECT or beat counter != 0

Function
REQ-007 SHALL implement FSM states COLLECT, ACK, RDATA, EMIT; reset state COLLECT.
REQ-008 In COLLECT, mem_rsp_ready_o SHALL be 1; in all other states 0.
REQ-009 Each accepted beat (valid&ready) SHALL be written to buffer slot indexed by a beat counter, which then increments.
REQ-010 mem_rsp_id_i SHALL be latched on the beat accepted with counter==0; ids of later beats are ignored.
REQ-011 Line SHALL complete on an accepted beat with mem_rsp_last_i=1 or counter==BEATS-1, whichever first; FSM -> ACK, counter -> 0.
REQ-012 Slots not written before early completion SHALL read as zero (buffer cleared when counter resets to 0).
REQ-013 In ACK (exactly one cycle) mshr_ack_o=mshr_ack_cs_o=1 with latched set/way; then -> RDATA.
REQ-014 In RDATA (one cycle) mshr_ack_req_id_i and mshr_ack_need_rsp_i SHALL be registered; then -> EMIT.
REQ-015 In EMIT refill_valid_o=1 with all refill_* outputs stable until refill_ready_i=1; on handshake -> COLLECT.
REQ-016 Latency: last beat accepted at cycle T -> mshr_ack_o at T+1 -> refill_valid_o first high at T+3.
REQ-017 mshr_ack_o SHALL never assert outside ACK, so no ack coincides with MSHR alloc/check driven by other units during COLLECT idle time.
REQ-018 mem_rsp_valid_i while not in COLLECT SHALL be back-pressured; no beat lost or duplicated.
REQ-019 refill_data_o, refill_req_id_o, refill_need_rsp_o SHALL be don't-care-free: hold last values outside EMIT.

Reset
REQ-020 Reset SHALL force COLLECT, counter 0, buffer 0, latched id 0, error flag 0; all outputs 0 except mem_rsp_ready_o=1 after reset release.
REQ-021 Reset asserted mid-line or in ACK/RDATA/EMIT SHALL discard the partial line without further ack or refill output.

Configuration
REQ-022 With HPDCACHE_REFILL_ERR_CHECK_EN defined, refill_error_o SHALL be the OR of mem_rsp_error_i over accepted beats of the line, OR-ed with a protocol error (last=1 before counter==BEATS-1, or counter==BEATS-1 with last=0); flag cleared on EMIT handshake.
REQ-023 Without HPDCACHE_REFILL_ERR_CHECK_EN, refill_error_o SHALL be constant 0 and no error state SHALL be synthesized; completion rules unchanged.

Verification
REQ-024 4 beats 0x11..0x44, id {way=1,set=2}, last on 4th -> ack set=2 way=1 at T+1, refill_data_o=0x44..0x33..0x22..0x11 (beat0 low), valid at T+3.
REQ-025 refill_ready_i held 0 for 5 cycles in EMIT while mem_rsp_valid_i=1 -> mem_rsp_ready_o=0 throughout, outputs stable, next line starts after handshake.
REQ-026 Error on beat 2 (ERR_CHECK_EN) -> refill_error_o=1; following clean line -> refill_error_o=0; without macro -> always 0.
REQ-027 Early last on beat 1 -> completion, slots 2..3 zero, refill_error_o=1 with macro.
REQ-028 MSHR returns req_id=0x2A, need_rsp=1 at T+2 -> refill_req_id_o=0x2A, refill_need_rsp_o=1.
REQ-029 rst_ni pulsed after 2 beats -> no mshr_ack_o, no refill_valid_o; fresh 4-beat line then completes normally.
